// File: rtl/row_length_sequencer_pkg.sv
// Shared widths, per-channel row counts and FSM encoding for the row-length sequencer.
package row_length_sequencer_pkg;

  localparam int unsigned RowLenSize  = 8;
  localparam int unsigned RowIdxW     = 16;
  localparam int unsigned NumChannels = 4;

  // Rows per matrix, indexed by channel; the multi-channel wrapper picks its entry.
  localparam int unsigned NumRowsTable [NumChannels] = '{256, 256, 128, 64};

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPop  = 3'd1;
  localparam logic [2:0] StLat  = 3'd2;
  localparam logic [2:0] StRun  = 3'd3;
  localparam logic [2:0] StZero = 3'd4;
  localparam logic [2:0] StNext = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  typedef struct packed {
    logic valid;
    logic last;
    logic row_done;
  } beat_tag_t;

  function automatic logic state_is_busy(input logic [2:0] st);
    return !(st == StIdle || st == StDone);
  endfunction

endpackage

// File: rtl/row_length_sequencer.sv
// Pops row lengths, issues one element read per row element and tags each beat with
// row index, last-of-row and row_done; detects end of matrix after NUM_ROWS rows.
module row_length_sequencer
  import row_length_sequencer_pkg::*;
#(
  parameter int unsigned ROW_LEN_SIZE = RowLenSize,
  parameter int unsigned ROW_IDX_W    = RowIdxW,
  parameter int unsigned NUM_ROWS     = NumRowsTable[0]
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    len_empty_i,
  output logic                    len_read_o,
  input  logic [ROW_LEN_SIZE-1:0] len_data_i,
  input  logic                    elem_empty_i,
  output logic                    elem_read_o,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic                    out_last_o,
  output logic                    row_done_o,
  output logic [ROW_IDX_W-1:0]    row_idx_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [ROW_IDX_W-1:0] LastRow = ROW_IDX_W'(NUM_ROWS - 1);

  logic [2:0]              state_q, state_d;
  logic [ROW_LEN_SIZE-1:0] rem_q, rem_d;
  logic [ROW_IDX_W-1:0]    row_q, row_d;
  beat_tag_t               tag_q, tag_d;
  logic                    final_beat;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    row_d       = row_q;
    len_read_o  = 1'b0;
    elem_read_o = 1'b0;
    final_beat  = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StPop;
          row_d   = '0;
        end
      end
      StPop: begin
        len_read_o = !len_empty_i;
        if (!len_empty_i) state_d = StLat;
      end
      StLat: begin
        rem_d   = len_data_i;
        state_d = (len_data_i == '0) ? StZero : StRun;
      end
      StRun: begin
        // The remaining != 0 term keeps the count from ever wrapping.
        elem_read_o = !elem_empty_i && out_ready_i && (rem_q != '0);
        final_beat  = elem_read_o && (rem_q == ROW_LEN_SIZE'(1));
        if (elem_read_o) begin
          rem_d = rem_q - ROW_LEN_SIZE'(1);
          if (final_beat) state_d = StNext;
        end
      end
      StZero: state_d = StNext;
      StNext: begin
        if (row_q == LastRow) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + ROW_IDX_W'(1);
          state_d = StPop;
        end
      end
      default: state_d = StIdle;
    endcase

    tag_d.valid    = elem_read_o;
    tag_d.last     = final_beat;
    tag_d.row_done = final_beat || (state_q == StZero);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      row_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      row_q   <= row_d;
      tag_q   <= tag_d;
    end
  end

  // row_q only advances in NEXT, after the row's tags have been emitted.
  assign out_valid_o = tag_q.valid;
  assign out_last_o  = tag_q.last;
  assign row_done_o  = tag_q.row_done;
  assign row_idx_o   = row_q;
  assign busy_o      = state_is_busy(state_q);
  assign done_o      = (state_q == StDone);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    elem_read_o |-> (rem_q != '0));
  a_last_has_beat: assert property (@(posedge clk) disable iff (rst)
    out_last_o |-> (out_valid_o && row_done_o));

endmodule

// File: tb/tb_row_length_sequencer.sv
// Randomized bench: models FIFOs, predicts the beat/row_done stream per matrix pass.
module tb_row_length_sequencer;

  localparam int unsigned LW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned NR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          len_empty_i = 1'b1;
  logic          elem_empty_i = 1'b1;
  logic          out_ready_i = 1'b0;
  logic [LW-1:0] len_data_i = '0;
  logic          len_read_o, elem_read_o, out_valid_o, out_last_o, row_done_o;
  logic [IW-1:0] row_idx_o;
  logic          busy_o, done_o;

  always #5 clk = ~clk;

  row_length_sequencer #(
    .ROW_LEN_SIZE (LW),
    .ROW_IDX_W    (IW),
    .NUM_ROWS     (NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .len_empty_i  (len_empty_i),
    .len_read_o   (len_read_o),
    .len_data_i   (len_data_i),
    .elem_empty_i (elem_empty_i),
    .elem_read_o  (elem_read_o),
    .out_ready_i  (out_ready_i),
    .out_valid_o  (out_valid_o),
    .out_last_o   (out_last_o),
    .row_done_o   (row_done_o),
    .row_idx_o    (row_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct packed {
    logic          v;
    logic          l;
    logic          d;
    logic [IW-1:0] r;
  } ev_t;

  ev_t         expq[$];
  int unsigned lenq[$];
  int          errors = 0;
  int          checks = 0;
  int          p_stall = 0, p_ee = 0, p_nr = 0, len_hold = 0;
  bit          toggle_ee = 0, poke = 0, rd_pend = 0, prev_er = 0;
  int          busy_cnt = 0, beats_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO side: dout updates after the edge that saw rd_en; empties re-drawn each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_pend) begin
      if (lenq.size() != 0) len_data_i = LW'(lenq.pop_front());
      rd_pend = 0;
    end
    len_empty_i = (lenq.size() == 0) || (len_hold > 0) ||
                  (int'($urandom_range(99)) < p_stall);
    if (len_hold > 0) len_hold--;
    elem_empty_i = toggle_ee ? !elem_empty_i : (int'($urandom_range(99)) < p_ee);
    out_ready_i  = int'($urandom_range(99)) >= p_nr;
  end

  // Per-cycle compare against the expected event stream and handshake rules.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_er = 0;
        rd_pend = 0;
      end else begin
        check("deliver", out_valid_o, prev_er);
        if (elem_read_o) check("elem_gate", {elem_empty_i, out_ready_i}, 2'b01);
        if (len_read_o) check("len_gate", len_empty_i, 0);
        check("busy_done_excl", busy_o & done_o, 0);
        if (out_valid_o || row_done_o) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_event: got %0h expected none",
                     {out_valid_o, out_last_o, row_done_o, row_idx_o});
          end else begin
            e = expq.pop_front();
            check("event", {out_valid_o, out_last_o, row_done_o, row_idx_o}, e);
          end
          if (out_valid_o) beats_seen++;
        end else begin
          check("stray_last", out_last_o, 0);
        end
        prev_er = elem_read_o;
        rd_pend = len_read_o;
        if (busy_o) busy_cnt++;
      end
    end
  end

  task automatic push_row(input int unsigned r, input int unsigned len);
    ev_t e;
    lenq.push_back(len);
    if (len == 0) begin
      e = '{v: 1'b0, l: 1'b0, d: 1'b1, r: IW'(r)};
      expq.push_back(e);
    end else begin
      for (int unsigned k = 1; k <= len; k++) begin
        e = '{v: 1'b1, l: (k == len), d: (k == len), r: IW'(r)};
        expq.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input int hold);
    @(posedge clk);
    #2;
    start_i  = 1;
    len_hold = hold;
    @(posedge clk);
    #2;
    start_i = 0;
  endtask

  task automatic run_pass(input int unsigned l0, input int unsigned l1, input int unsigned l2,
                          input int hold, input int exp_busy, input string tag);
    int n;
    push_row(0, l0);
    push_row(1, l1);
    push_row(2, l2);
    busy_cnt = 0;
    pulse_start(hold);
    n = 0;
    while (!done_o && n < 5000) begin
      @(negedge clk);
      start_i = (poke && busy_o && $urandom_range(19) == 0);
      n++;
    end
    start_i = 0;
    check({tag, " finished"}, n < 5000, 1);
    check({tag, " drained"}, expq.size(), 0);
    check({tag, " len_fifo_used"}, lenq.size(), 0);
    check({tag, " last_row_idx"}, row_idx_o, NR - 1);
    if (exp_busy >= 0) check({tag, " busy_cycles"}, busy_cnt, exp_busy);
    repeat (3) @(negedge clk);
    check({tag, " done_held"}, {done_o, busy_o, row_idx_o}, {1'b1, 1'b0, IW'(NR - 1)});
    expq.delete();
    lenq.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    int unsigned a, b, c;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {len_read_o, elem_read_o, out_valid_o, out_last_o, row_done_o,
                            row_idx_o, busy_o, done_o}, 0);
    @(posedge clk);
    #3;
    rst = 0;
    @(negedge clk);
    check("idle_after_reset", {out_valid_o, row_done_o, row_idx_o, busy_o, done_o}, 0);

    // Busy = sum over rows of (3 + len), or 4 for an empty row.
    run_pass(3, 1, 2, 0, 15, "p312");
    run_pass(0, 2, 0, 0, 13, "p020");
    toggle_ee = 1;
    run_pass(4, 1, 0, 0, -1, "p410_toggle");
    toggle_ee = 0;
    p_nr = 50;
    run_pass(5, 2, 1, 0, -1, "p5_backpressure");
    p_nr = 0;
    run_pass(3, 1, 2, 10, 25, "p312_len_stall");
    run_pass(255, 0, 1, 0, 266, "p255");

    poke = 1;
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 9);
      b = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 9);
      c = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 9);
      p_stall = int'($urandom_range(40));
      p_ee    = int'($urandom_range(50));
      p_nr    = int'($urandom_range(50));
      run_pass(a, b, c, 0, -1, "random");
    end
    poke = 0; p_stall = 0; p_ee = 0; p_nr = 0;

    // Reset in the middle of a length-7 row.
    push_row(0, 7);
    lenq.push_back(1);
    lenq.push_back(1);
    base = beats_seen;
    pulse_start(0);
    n = 0;
    while (beats_seen - base < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrun_reached", n < 200, 1);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("midrun_reset_outputs", {len_read_o, elem_read_o, out_valid_o, out_last_o,
                                   row_done_o, row_idx_o, busy_o, done_o}, 0);
    expq.delete();
    lenq.delete();
    rd_pend = 0;
    @(posedge clk);
    #3;
    rst = 0;
    run_pass(2, 0, 3, 0, 15, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
